// File: rtl/regfile_wb_arbiter.sv
// Write-side arbiter for the register file: merges ALU results and FIFO-buffered load returns.
// Optional: define WB_LOAD_BYPASS_EN to let a load into an idle unit skip the FIFO.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic [4:0]  pend_reg,
  output logic        pend_hit,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {SEL_IDLE, SEL_POP, SEL_ALU, SEL_BYP} sel_t;

  logic [4:0]    freg  [DEPTH];
  logic [31:0]   fdata [DEPTH];
  logic [DEPTH-1:0] fvld;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic full, empty, mem_acc, enq, pop;
  sel_t sel;

  assign full      = (count == FULL);
  assign empty     = (count == '0);
  assign alu_ready = !full;
  assign mem_ready = !full;
  assign mem_acc   = mem_valid && !full;

  // Output-slot priority: full FIFO first, then ALU, then FIFO drain.
  always_comb begin
    sel = SEL_IDLE;
    if (full)
      sel = SEL_POP;
    else if (alu_valid)
      sel = SEL_ALU;
    else if (!empty)
      sel = SEL_POP;
`ifdef WB_LOAD_BYPASS_EN
    else if (mem_acc && (mem_reg != '0))
      sel = SEL_BYP;
`endif
  end

  assign pop = (sel == SEL_POP);
  assign enq = mem_acc && (mem_reg != '0) && (sel != SEL_BYP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      unique case (sel)
        SEL_POP: begin
          RegWrite  <= 1'b1;
          WriteReg  <= freg[rptr];
          WriteData <= fdata[rptr];
        end
        SEL_ALU: begin
          RegWrite  <= (alu_reg != '0);
          WriteReg  <= alu_reg;
          WriteData <= alu_data;
        end
        SEL_BYP: begin
          RegWrite  <= 1'b1;
          WriteReg  <= mem_reg;
          WriteData <= mem_data;
        end
        default: RegWrite <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      fvld  <= '0;
    end else begin
      // Enqueue and pop never target the same slot: that needs empty-with-pop or full-with-enqueue.
      if (pop) begin
        rptr       <= rptr + 1'b1;
        fvld[rptr] <= 1'b0;
      end
      if (enq) begin
        wptr       <= wptr + 1'b1;
        fvld[wptr] <= 1'b1;
      end
      if (enq && !pop)
        count <= count + 1'b1;
      else if (pop && !enq)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      freg[wptr]  <= mem_reg;
      fdata[wptr] <= mem_data;
    end
  end

  always_comb begin
    pend_hit = 1'b0;
    if (pend_reg != '0) begin
      if (RegWrite && (WriteReg == pend_reg))
        pend_hit = 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++)
        if (fvld[i] && (freg[i] == pend_reg))
          pend_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed steps plus random traffic against a queue model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
`ifdef WB_LOAD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_reg, mem_reg, pend_reg;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, pend_hit, RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .pend_reg(pend_reg), .pend_hit(pend_hit),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;
  ent_t        q[$];
  logic        m_rw = 1'b0;
  logic [4:0]  m_wreg = '0;
  logic [31:0] m_wdata = '0;
  bit          last_alu_acc, last_mem_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic [4:0] pr);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    pend_reg  = pr;
  endtask

  // Check DUT against the model, advance the model across one edge, land on the next negedge.
  task automatic step();
    bit   full, hit, byp_taken, mem_acc;
    ent_t e;
    #1;
    full = (q.size() == DEPTH);
    chk("mem_ready", mem_ready, !full);
    chk("alu_ready", alu_ready, !full);
    chk("RegWrite", RegWrite, m_rw);
    if (m_rw) begin
      chk("WriteReg", WriteReg, m_wreg);
      chk("WriteData", WriteData, m_wdata);
    end
    hit = 1'b0;
    if (pend_reg != 0) begin
      if (m_rw && m_wreg == pend_reg) hit = 1'b1;
      foreach (q[i]) if (q[i].r == pend_reg) hit = 1'b1;
    end
    chk("pend_hit", pend_hit, hit);

    mem_acc   = mem_valid && !full;
    byp_taken = 1'b0;
    if (full || (!alu_valid && q.size() != 0)) begin
      e = q.pop_front();
      m_rw = 1'b1; m_wreg = e.r; m_wdata = e.d;
    end else if (alu_valid) begin
      m_rw = (alu_reg != 0); m_wreg = alu_reg; m_wdata = alu_data;
    end else if (BYP && mem_acc && mem_reg != 0) begin
      m_rw = 1'b1; m_wreg = mem_reg; m_wdata = mem_data;
      byp_taken = 1'b1;
    end else begin
      m_rw = 1'b0;
    end
    if (mem_acc && mem_reg != 0 && !byp_taken) begin
      e.r = mem_reg; e.d = mem_data;
      q.push_back(e);
    end
    last_alu_acc = alu_valid && !full;
    last_mem_acc = mem_acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  task automatic reset_mid();
    #2 reset = 1'b1;
    #1;
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_pend_hit", pend_hit, 0);
    q.delete();
    m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_RegWrite", RegWrite, 0);
    chk("reset_WriteReg", WriteReg, 0);
    chk("reset_WriteData", WriteData, 0);
    chk("reset_mem_ready", mem_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // ALU-only write
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step();
    chk("alu_RegWrite", RegWrite, 1);
    chk("alu_WriteReg", WriteReg, 5);
    chk("alu_WriteData", WriteData, 32'hDEADBEEF);
    idle(1);
    chk("alu_done", RegWrite, 0);

    // Fill the FIFO behind a busy ALU, then watch ordering
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'hA0 + i, 1, 5'(7 + i), 32'h11 * (i + 1), 0);
      step();
    end
    chk("full_mem_ready", mem_ready, 0);
    drive(1, 1, 32'hB0, 0, 0, 0, 0);
    step();
    chk("full_pop_reg", WriteReg, 7);
    chk("full_pop_data", WriteData, 32'h11);
    step();
    chk("alu_resume", WriteReg, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drain_order", WriteReg, 8 + i);
    end
    idle(2);

    // Register $0
    drive(1, 0, 32'h1234, 0, 0, 0, 0);
    step();
    chk("alu_r0", RegWrite, 0);
    drive(0, 0, 0, 1, 0, 32'h5678, 0);
    step();
    chk("load_r0_none", RegWrite, 0);
    idle(3);

    // Pending query
    drive(1, 2, 32'h22, 1, 12, 32'hC0C0, 12);
    step();
    drive(1, 2, 32'h23, 0, 0, 0, 12);
    #1 chk("pend_12", pend_hit, 1);
    pend_reg = 13;
    #1 chk("pend_13", pend_hit, 0);
    pend_reg = 0;
    #1 chk("pend_0", pend_hit, 0);
    pend_reg = 12;
    step();
    drive(0, 0, 0, 0, 0, 0, 12);
    step();
    chk("pend_wr12", WriteReg, 12);
    chk("pend_during_write", pend_hit, 1);
    step();
    chk("pend_drop", pend_hit, 0);
    idle(2);

    // Load latency (bypass vs. FIFO)
    drive(0, 0, 0, 1, 3, 32'h55, 0);
    step();
    chk("lat_e1", RegWrite, BYP);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("lat_e2", RegWrite, !BYP);
    if (!BYP) chk("lat_e2_reg", WriteReg, 3);
    idle(2);

    // Reset with three loads queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 4, 32'h40 + i, 1, 5'(20 + i), 32'h900 + i, 0);
      step();
    end
    chk("pre_rst_depth", q.size(), 3);
    pend_reg = 21;
    reset_mid();
    idle(6);

    // Random traffic; producers hold requests until accepted
    last_alu_acc = 1'b1;
    last_mem_acc = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (!alu_valid || last_alu_acc) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_reg   = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      if (!mem_valid || last_mem_acc) begin
        mem_valid = ($urandom_range(0, 9) < 5);
        mem_reg   = 5'($urandom_range(0, 31));
        mem_data  = $urandom;
      end
      if (q.size() != 0 && $urandom_range(0, 1) == 1)
        pend_reg = q[$urandom_range(0, q.size() - 1)].r;
      else
        pend_reg = 5'($urandom_range(0, 31));
      step();
    end
    idle(DEPTH + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-side front end for the 32x32 register file. It merges two writeback producers onto the single register-file write port (RegWrite/WriteReg/WriteData):
- the single-cycle ALU result path;
- the variable-latency load-return path, buffered in a small FIFO.

It also exports a pending-write query so the hazard logic can stall readers of registers whose writes have not yet landed.

Parameters:
- DEPTH, 4, load-return FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU writeback request this cycle
- alu_reg  input  5  ALU destination register
- alu_data  input  32  ALU result
- alu_ready  output  1  ALU request accepted this cycle
- mem_valid  input  1  load-return request
- mem_reg  input  5  load destination register
- mem_data  input  32  load data
- mem_ready  output  1  load return accepted this cycle
- pend_reg  input  5  register number to query
- pend_hit  output  1  a write to pend_reg is still outstanding
- RegWrite  output  1  register-file write enable, registered
- WriteReg  output  5  register-file write address, registered
- WriteData  output  32  register-file write data, registered

Behaviour:
- Clock/reset: one clock domain (clk). reset is asynchronous, active-high.
- Reset values: RegWrite=0, WriteReg=0, WriteData=0, FIFO count=0, read/write pointers=0.
- Reset mid-operation discards all queued and in-flight writes; nothing is written after reset.
- Handshakes:
  - mem_ready = (count != DEPTH). A load is accepted on an edge where mem_valid && mem_ready.
  - alu_ready = (count != DEPTH). An ALU request is accepted on an edge where alu_valid && alu_ready; a producer must hold valid/reg/data stable until accepted.
  - Both ready signals are combinational from state only, never from the valid inputs.
- Output slot selection at each edge, first match wins:
  1. count == DEPTH: pop the FIFO head into the output register.
  2. alu_valid (therefore ready): load the ALU request into the output register.
  3. count != 0: pop the FIFO head.
  4. Otherwise: RegWrite <= 0; WriteReg and WriteData hold their values.
- Register $0:
  - An accepted ALU write to $0 occupies the output slot with RegWrite <= 0.
  - An accepted load to $0 completes the handshake but is not enqueued.
- FIFO:
  - An accepted load (reg != 0) is written at the write pointer on the same edge.
  - Enqueue and pop on the same edge leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - While full, mem_ready=0, so no enqueue can coincide with a full-pop edge.
- Latency:
  - ALU: accepted at edge E, RegWrite=1 during cycle E+1.
  - Load into an empty FIFO with ALU idle: enqueued at E, popped at E+1, RegWrite=1 during cycle E+2.
- Ordering:
  - Loads retire in arrival order.
  - ALU writes may overtake queued loads except when the FIFO is full.
  - The producer guarantees no WAW ordering is required between the two paths.
- pend_hit is combinational and asserts when pend_reg != 0 and either:
  - any valid FIFO entry's register equals pend_reg, or
  - RegWrite=1 and WriteReg equals pend_reg.
- No starvation: the FIFO always drains when full, and drains whenever the ALU is idle.

Optional Feature:
- Macro: WB_LOAD_BYPASS_EN.
- Defined: when count == 0, alu_valid == 0 and an accepted load has mem_reg != 0, the load is written directly into the output register on the acceptance edge without enqueueing. RegWrite=1 during cycle E+1, so load latency is 1.
- Undefined: every non-$0 load passes through the FIFO, with latency 2 minimum.
- All other rules are identical in both cases.

Test Plan:
- Reset: assert reset mid-stream with 3 entries queued -> RegWrite=0 immediately (asynchronous); count=0, mem_ready=1; no writes after release.
- ALU only: alu_valid=1, alu_reg=5, alu_data=0xDEADBEEF at edge E -> cycle E+1 shows RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF; next cycle RegWrite=0.
- Load queuing and order:
  - Stimulus: loads to r7=0x11, r8=0x22, r9=0x33, r10=0x44 on consecutive edges while alu_valid=1 continuously to r1.
  - Required: FIFO fills and mem_ready=0; the full-pop writes r7; ALU writes resume; the remaining loads drain in order r8, r9, r10 once the ALU is idle.
- Register $0: ALU to r0 -> RegWrite stays 0 that cycle. Load to r0 -> mem_ready handshake completes, count unchanged, no write ever appears.
- Pending query:
  - After enqueueing a load to r12, pend_reg=12 -> pend_hit=1.
  - pend_reg=13 -> pend_hit=0.
  - pend_hit stays 1 through the cycle RegWrite=1/WriteReg=12, then drops.
  - pend_reg=0 -> pend_hit=0 always.
- Bypass, with WB_LOAD_BYPASS_EN defined: idle unit, load r3=0x55 at E -> RegWrite=1, WriteReg=3 in cycle E+1. Without the macro: same stimulus gives RegWrite=1 in cycle E+2.
